// File: rtl/wb_slave_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slave_mux_if
//  Brief    : Bus bundle for the Wishbone one-to-many slave mux. Carries the
//             granted master's request/response and the fan-out slave side.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_slave_mux_if #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int NUM_SLAVES = 2
);
    // Master side
    logic [AW-1:0]            wbm_adr_i;
    logic [DW-1:0]            wbm_dat_i;
    logic [3:0]               wbm_sel_i;
    logic                     wbm_we_i;
    logic                     wbm_cyc_i;
    logic                     wbm_stb_i;
    logic [2:0]               wbm_cti_i;
    logic [1:0]               wbm_bte_i;
    logic [DW-1:0]            wbm_dat_o;
    logic                     wbm_ack_o;
    logic                     wbm_err_o;
    logic                     wbm_rty_o;
    // Slave side
    logic [AW-1:0]            wbs_adr_o;
    logic [DW-1:0]            wbs_dat_o;
    logic [3:0]               wbs_sel_o;
    logic                     wbs_we_o;
    logic [2:0]               wbs_cti_o;
    logic [1:0]               wbs_bte_o;
    logic [NUM_SLAVES-1:0]    wbs_cyc_o;
    logic [NUM_SLAVES-1:0]    wbs_stb_o;
    logic [NUM_SLAVES*DW-1:0] wbs_dat_i;
    logic [NUM_SLAVES-1:0]    wbs_ack_i;
    logic [NUM_SLAVES-1:0]    wbs_err_i;
    logic [NUM_SLAVES-1:0]    wbs_rty_i;
    // Status
    logic                     timeout_o;

    // The mux itself: it is the slave of the granted master
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o,
               wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output timeout_o
    );

    // The surrounding environment: drives requests and slave responses
    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
               wbm_cti_i, wbm_bte_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o,
               wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input  timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_slave_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slave_mux
//  Brief    : Wishbone 1:N interconnect stage. Decodes the address against
//             per-slave match/mask windows, locks the chosen slave for the
//             whole bus cycle, and terminates unmapped or stalled accesses
//             with a single-cycle error.
//  Revision : 1.0  initial release
// ============================================================================
module wb_slave_mux #(
    parameter int                         DW             = 32,
    parameter int                         AW             = 32,
    parameter int                         NUM_SLAVES     = 2,
    parameter logic [NUM_SLAVES*AW-1:0]   MATCH_ADDR     = '0,
    parameter logic [NUM_SLAVES*AW-1:0]   MATCH_MASK     = '0,
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_slave_mux_if.slave     bus
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERR    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;     // registered timeout error pulse
    logic               to_q, to_d;       // registered timeout flag pulse

    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_any_hit;
    logic [SEL_W-1:0]      w_hit_idx;
    logic                  w_s_ack, w_s_err, w_s_rty, w_s_resp;
    logic [DW-1:0]         w_s_dat;
    logic [NUM_SLAVES-1:0] w_cyc, w_stb;
    logic                  w_ack, w_err, w_rty;
    logic [DW-1:0]         w_dat;

    // Request fields are broadcast unregistered; only cyc/stb are steered
    assign bus.wbs_adr_o = bus.wbm_adr_i;
    assign bus.wbs_dat_o = bus.wbm_dat_i;
    assign bus.wbs_sel_o = bus.wbm_sel_i;
    assign bus.wbs_we_o  = bus.wbm_we_i;
    assign bus.wbs_cti_o = bus.wbm_cti_i;
    assign bus.wbs_bte_o = bus.wbm_bte_i;

    generate
        for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_decode
            assign w_hit[i] = ((bus.wbm_adr_i ^ MATCH_ADDR[i*AW +: AW])
                               & MATCH_MASK[i*AW +: AW]) == '0;
        end
    endgenerate

    // Priority encode the window hits; the lowest index wins on overlap
    always_comb begin
        w_hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_hit_idx = SEL_W'(i);
        end
    end
    assign w_any_hit = |w_hit;

    // Responses of the slave locked for the current cycle
    assign w_s_ack  = bus.wbs_ack_i[sel_q];
    assign w_s_err  = bus.wbs_err_i[sel_q];
    assign w_s_rty  = bus.wbs_rty_i[sel_q];
    assign w_s_resp = w_s_ack | w_s_err | w_s_rty;
    assign w_s_dat  = bus.wbs_dat_i[sel_q*DW +: DW];

    // Next-state, stall counter and steering of strobes/responses
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        to_d    = 1'b0;
        w_cyc   = '0;
        w_stb   = '0;
        w_ack   = 1'b0;
        w_err   = err_q;
        w_rty   = 1'b0;
        w_dat   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    if (w_any_hit) begin
                        sel_d   = w_hit_idx;
                        cnt_d   = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ACTIVE: begin
                w_cyc[sel_q] = bus.wbm_cyc_i;
                w_stb[sel_q] = bus.wbm_stb_i;
                w_ack        = w_s_ack;
                w_err        = err_q | w_s_err;
                w_rty        = w_s_rty;
                w_dat        = w_s_dat;
                if (!bus.wbm_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (w_s_resp || !bus.wbm_stb_i) begin
                    cnt_d = '0;
                end else if (TO_EN && (cnt_q == CNT_LIMIT)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERR: begin
                w_err   = 1'b1;
                state_d = bus.wbm_cyc_i ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.wbm_cyc_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign bus.wbs_cyc_o = w_cyc;
    assign bus.wbs_stb_o = w_stb;
    assign bus.wbm_ack_o = w_ack;
    assign bus.wbm_err_o = w_err;
    assign bus.wbm_rty_o = w_rty;
    assign bus.wbm_dat_o = w_dat;
    assign bus.timeout_o = to_q;

endmodule
`default_nettype wire
